// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control unit: sequences fetch, decode, execute,
// memory, write-back and multiply/divide wait, and drives the datapath
// strobes for each step. Outputs are decoded from the current state and the
// latched instruction fields. They are forced to their idle values whenever
// rst_n is low.
module mc_control_fsm #(
  parameter int unsigned MD_LATENCY = 5,    // MDWAIT cycles per mult/div, 1..15
  parameter bit          ENABLE_MD  = 1'b1  // 0: mult/div/mfhi/mflo are illegal
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] option,
  input  logic [5:0] func,
  input  logic       instr_valid,
  input  logic       mem_ack,
  input  logic       zero,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write_enable,
  output logic       mem_read_enable,
  output logic       mem_write_enable,
  output logic [1:0] reg_write_src,
  output logic [1:0] reg_destination,
  output logic [2:0] ALUoption,
  output logic       ALUsrc,
  output logic       imm_extend_op,
  output logic [1:0] jump,
  output logic       md_start,
  output logic       md_busy,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    MDWAIT    = 3'd5,
    TRAP      = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_J, I_JAL, I_JR,
    I_MULT, I_DIV, I_MFHI, I_MFLO, I_ILL
  } instr_e;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_CMP  = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;
  localparam logic [2:0] ALU_IDLE = 3'b111;

  // Write-back source, destination and PC source selects
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;
  localparam logic [1:0] SRC_HL  = 2'b11;
  localparam logic [1:0] DST_RD  = 2'b00;
  localparam logic [1:0] DST_RT  = 2'b01;
  localparam logic [1:0] DST_RA  = 2'b10;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JT   = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  // The counter is preloaded with MD_LATENCY-1 so that MDWAIT spans
  // MD_LATENCY cycles, counting down to and including zero.
  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 32'd1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  instr_e     instr;

  // Classify the latched instruction fields into one decoded operation.
  always_comb begin
    instr = I_ILL;
    case (option)
      6'b000000: begin
        case (func)
          6'b100000: instr = I_ADD;
          6'b100010: instr = I_SUB;
          6'b001000: instr = I_JR;
          6'b011000: instr = ENABLE_MD ? I_MULT : I_ILL;
          6'b011010: instr = ENABLE_MD ? I_DIV  : I_ILL;
          6'b010000: instr = ENABLE_MD ? I_MFHI : I_ILL;
          6'b010010: instr = ENABLE_MD ? I_MFLO : I_ILL;
          default:   instr = I_ILL;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b001111: instr = I_LUI;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_ILL;
    endcase
  end

  // Next-state, counter and output decode for the current state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_d          = state_q;
    cnt_d            = cnt_q;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    reg_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    reg_write_src    = SRC_ALU;
    reg_destination  = DST_RD;
    ALUoption        = ALU_IDLE;
    ALUsrc           = 1'b0;
    imm_extend_op    = 1'b0;
    jump             = PC_SEQ;
    md_start         = 1'b0;
    md_busy          = 1'b0;

    // FETCH outputs depend on instr_valid, so the whole decode is gated by
    // rst_n to keep every strobe idle while reset is held.
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          if (instr_valid) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            jump     = PC_SEQ;
            state_d  = DECODE;
          end
        end

        DECODE: begin
          case (instr)
            I_ILL: state_d = TRAP;
            I_J: begin
              pc_write = 1'b1;
              jump     = PC_JT;
              state_d  = FETCH;
            end
            I_JAL: begin
              reg_write_enable = 1'b1;
              reg_destination  = DST_RA;
              reg_write_src    = SRC_PC4;
              pc_write         = 1'b1;
              jump             = PC_JT;
              state_d          = FETCH;
            end
            I_JR: begin
              pc_write = 1'b1;
              jump     = PC_REG;
              state_d  = FETCH;
            end
            default: state_d = EXECUTE;
          endcase
        end

        EXECUTE: begin
          case (instr)
            I_ADD: begin
              ALUoption = ALU_ADD;
              state_d   = WRITEBACK;
            end
            I_SUB: begin
              ALUoption = ALU_SUB;
              state_d   = WRITEBACK;
            end
            I_ORI: begin
              ALUoption = ALU_OR;
              ALUsrc    = 1'b1;
              state_d   = WRITEBACK;
            end
            I_LUI: begin
              ALUoption = ALU_LUI;
              ALUsrc    = 1'b1;
              state_d   = WRITEBACK;
            end
            I_LW, I_SW: begin
              ALUoption     = ALU_ADD;
              ALUsrc        = 1'b1;
              imm_extend_op = 1'b1;
              state_d       = MEMORY;
            end
            I_BEQ: begin
              ALUoption     = ALU_CMP;
              imm_extend_op = 1'b1;
              jump          = PC_BR;
              pc_write      = zero;
              state_d       = FETCH;
            end
            I_MULT, I_DIV: begin
              md_start = 1'b1;
              cnt_d    = MD_LOAD;
              state_d  = MDWAIT;
            end
            I_MFHI, I_MFLO: begin
              reg_write_src = SRC_HL;
              state_d       = WRITEBACK;
            end
            default: state_d = TRAP;
          endcase
        end

        MEMORY: begin
          // Address stays on the ALU for the whole access.
          ALUoption     = ALU_ADD;
          ALUsrc        = 1'b1;
          imm_extend_op = 1'b1;
          if (instr == I_SW) mem_write_enable = 1'b1;
          else               mem_read_enable  = 1'b1;
          if (mem_ack) state_d = (instr == I_SW) ? FETCH : WRITEBACK;
        end

        WRITEBACK: begin
          reg_write_enable = 1'b1;
          case (instr)
            I_LW: begin
              reg_write_src   = SRC_MEM;
              reg_destination = DST_RT;
            end
            I_ORI, I_LUI: reg_destination = DST_RT;
            I_MFHI, I_MFLO: reg_write_src = SRC_HL;
            default: reg_destination = DST_RD;
          endcase
          state_d = FETCH;
        end

        MDWAIT: begin
          md_busy = 1'b1;
          if (cnt_q == 4'd0) state_d = FETCH;
          else               cnt_d   = cnt_q - 4'd1;
        end

        TRAP:    state_d = TRAP;
        default: state_d = TRAP;
      endcase
    end
  end

  // The trap flag latches on entry to TRAP and holds until reset.
  always_comb illegal_d = illegal_q | (state_d == TRAP);

  // State register, MDWAIT counter and sticky trap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MD_LATENCY, 5, MDWAIT cycles per mult/div; legal range 1..15.
REQ-002 Parameter ENABLE_MD, 1, 1 = mult/div/mfhi/mflo decoded, 0 = those four are illegal.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 option  in  6  opcode field of the latched instruction.
REQ-006 func  in  6  funct field of the latched instruction.
REQ-007 instr_valid  in  1  fetch data valid.
REQ-008 mem_ack  in  1  data memory completes the current access.
REQ-009 zero  in  1  ALU equality flag for beq.
REQ-010 ir_write, pc_write  out  1 each  instruction-register load, PC load.
REQ-011 reg_write_enable, mem_read_enable, mem_write_enable  out  1 each  register-file and memory strobes.
REQ-012 reg_write_src  out  2  00 ALU, 01 memory, 10 PC+4, 11 HI/LO.
REQ-013 reg_destination  out  2  00 rd, 01 rt, 10 $31.
REQ-014 ALUoption  out  3  010 add, 110 sub, 001 or, 011 compare, 100 lui, 111 idle.
REQ-015 ALUsrc, imm_extend_op  out  1 each  immediate operand select, sign-extend (1) vs zero-extend (0).
REQ-016 jump  out  2  00 PC+4, 01 branch, 10 j-target, 11 register.
REQ-017 md_start, md_busy, illegal  out  1 each  MDU start pulse, MDU busy, sticky trap flag.
REQ-018 state  out  3  current state code.

Function
REQ-019 States SHALL be encoded FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, MDWAIT=5, TRAP=6; code 7 SHALL go to TRAP.
REQ-020 Decoded set SHALL be add, sub, ori, lw, sw, beq, lui, j, jal, jr, plus mult (func 011000), div (011010), mfhi (010000), mflo (010010), all with option 000000 for R-type.
REQ-021 FETCH SHALL hold while instr_valid=0; with instr_valid=1 it SHALL assert ir_write=1, pc_write=1, jump=00 for one cycle, then go to DECODE.
REQ-022 DECODE illegal instruction SHALL go to TRAP; j SHALL assert pc_write with jump=10, then go to FETCH.
REQ-023 DECODE jal SHALL assert reg_write_enable, reg_destination=10, reg_write_src=10, pc_write and jump=10 in the same cycle, then go to FETCH.
REQ-024 DECODE jr SHALL assert pc_write with jump=11, then go to FETCH; every other legal instruction SHALL go to EXECUTE.
REQ-025 EXECUTE add/sub/ori/lui SHALL drive the ALUoption/ALUsrc/imm_extend_op codes of REQ-014/015 (ori and lui zero-extend), then go to WRITEBACK.
REQ-026 EXECUTE lw/sw SHALL drive ALUoption=010, ALUsrc=1, imm_extend_op=1, then go to MEMORY.
REQ-027 EXECUTE beq SHALL drive ALUoption=011, imm_extend_op=1, jump=01, pc_write=zero, then go to FETCH.
REQ-028 EXECUTE mult/div SHALL pulse md_start for one cycle, load the counter with MD_LATENCY-1, then go to MDWAIT.
REQ-029 EXECUTE mfhi/mflo SHALL go to WRITEBACK with reg_write_src=11.
REQ-030 MEMORY SHALL hold mem_read_enable (lw) or mem_write_enable (sw) every cycle until mem_ack=1.
REQ-031 In the mem_ack cycle MEMORY SHALL go to WRITEBACK (lw) or FETCH (sw); a mem_ack seen outside MEMORY SHALL be ignored.
REQ-032 WRITEBACK SHALL assert reg_write_enable for exactly one cycle with destination rd (R-type) or rt (ori/lw/lui), then go to FETCH.
REQ-033 MDWAIT SHALL hold md_busy=1 and decrement the counter each cycle, going to FETCH in the cycle the counter equals 0; MDWAIT therefore lasts exactly MD_LATENCY cycles.
REQ-034 The counter SHALL be 4 bits and SHALL never wrap below 0.
REQ-035 TRAP SHALL set illegal=1 and hold every enable and strobe at 0 until reset.
REQ-036 Every strobe not named for a state SHALL be 0 in that state; ALUoption SHALL be 111 outside EXECUTE and MEMORY.

Reset
REQ-037 While rst_n=0 the block SHALL force state=FETCH, counter=0, illegal=0, every strobe and enable to 0, every multi-bit control to 0 and ALUoption to 111, independent of clk.
REQ-038 Reset asserted mid-MEMORY or mid-MDWAIT SHALL drop mem_*_enable and md_busy immediately, with no completion of the access.
REQ-039 After rst_n rises, the first active edge SHALL evaluate FETCH.

Verification
REQ-040 add, instr_valid=1 -> FETCH, DECODE, EXECUTE, WRITEBACK (4 cycles), one reg_write_enable pulse with reg_destination=00.
REQ-041 lw with mem_ack delayed 3 cycles -> mem_read_enable high for 3 MEMORY cycles, then WRITEBACK with reg_write_src=01; 7 cycles total.
REQ-042 mult, MD_LATENCY=5 -> one md_start pulse, md_busy high for exactly 5 cycles, back to FETCH on cycle 9.
REQ-043 beq with zero=0, then beq with zero=1 -> pc_write=0, then pc_write=1 with jump=01 in EXECUTE.
REQ-044 option=111111, or mult with ENABLE_MD=0 -> TRAP, illegal=1 sticky; rst_n pulse clears it and state=0.
REQ-045 rst_n low during sw MEMORY -> mem_write_enable=0 before the next clk edge, state=0.
